// File: rtl/sp_stream_bank_if.sv
// Bus bundle for sp_stream_bank: write port, direct read port and stream port.
// master = requester side, slave = the bank itself.
interface sp_stream_bank_if #(
  parameter int unsigned SP_NTARGETS = 4,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned BUS_WIDTH   = 64
);
  localparam int unsigned MAX_DIM = BUS_WIDTH / DATA_WIDTH;
  localparam int unsigned ROWS    = MAX_DIM * MAX_DIM;
  localparam int unsigned AW      = $clog2(ROWS);
  localparam int unsigned TW      = $clog2(SP_NTARGETS);

  logic                 wr_en_i;
  logic [TW-1:0]        wr_target_i;
  logic [AW-1:0]        wr_addr_i;
  logic [BUS_WIDTH-1:0] wr_data_i;
  logic                 rd_en_i;
  logic [TW-1:0]        rd_target_i;
  logic [AW-1:0]        rd_addr_i;
  logic [BUS_WIDTH-1:0] rd_data_o;
  logic                 rd_valid_o;
  logic                 st_start_i;
  logic [TW-1:0]        st_target_i;
  logic                 st_abort_i;
  logic [BUS_WIDTH-1:0] st_data_o;
  logic                 st_valid_o;
  logic                 st_ready_i;
  logic                 st_last_o;
  logic                 st_busy_o;
  logic                 st_done_o;

  modport master (
    output wr_en_i, wr_target_i, wr_addr_i, wr_data_i,
    output rd_en_i, rd_target_i, rd_addr_i,
    input  rd_data_o, rd_valid_o,
    output st_start_i, st_target_i, st_abort_i, st_ready_i,
    input  st_data_o, st_valid_o, st_last_o, st_busy_o, st_done_o
  );

  modport slave (
    input  wr_en_i, wr_target_i, wr_addr_i, wr_data_i,
    input  rd_en_i, rd_target_i, rd_addr_i,
    output rd_data_o, rd_valid_o,
    input  st_start_i, st_target_i, st_abort_i, st_ready_i,
    output st_data_o, st_valid_o, st_last_o, st_busy_o, st_done_o
  );
endinterface

// File: rtl/sp_stream_bank.sv
// Multi-target result scratchpad with a direct read port and a burst streaming engine.
// Optional SP_CLEAR_ON_STREAM_EN: streamed rows are zeroed as their beat transfers.
module sp_stream_bank #(
  parameter int unsigned SP_NTARGETS = 4,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned BUS_WIDTH   = 64
) (
  input logic              clk_i,
  input logic              rst_ni,
  sp_stream_bank_if.slave  bus
);
  localparam int unsigned MAX_DIM = BUS_WIDTH / DATA_WIDTH;
  localparam int unsigned ROWS    = MAX_DIM * MAX_DIM;
  localparam int unsigned AW      = $clog2(ROWS);
  localparam int unsigned TW      = $clog2(SP_NTARGETS);
  localparam int unsigned IW      = TW + AW;
  localparam int unsigned Depth   = SP_NTARGETS * ROWS;
  localparam logic [AW-1:0] LastRow = AW'(ROWS - 1);

  typedef enum logic [1:0] {StIdle, StStream, StDone} st_e;

  st_e                  state_q, state_d;
  logic [AW-1:0]        ptr_q, ptr_d;
  logic [TW-1:0]        tgt_q, tgt_d;
  logic                 st_valid_q, st_valid_d;
  logic [BUS_WIDTH-1:0] st_data_q;
  logic [BUS_WIDTH-1:0] rd_data_q;
  logic                 rd_valid_q;
  logic [BUS_WIDTH-1:0] mem_q [Depth];

  logic                 load;
  logic [IW-1:0]        load_idx;
  logic                 xfer;
  logic                 last_row;
  logic [IW-1:0]        wr_idx, rd_idx, cur_idx;

  // Widened before the multiply so target*ROWS+row never wraps.
  function automatic logic [IW-1:0] row_idx(input logic [TW-1:0] t, input logic [AW-1:0] r);
    return IW'(t) * IW'(ROWS) + IW'(r);
  endfunction

  assign wr_idx   = row_idx(bus.wr_target_i, bus.wr_addr_i);
  assign rd_idx   = row_idx(bus.rd_target_i, bus.rd_addr_i);
  assign cur_idx  = row_idx(tgt_q, ptr_q);
  assign last_row = (ptr_q == LastRow);
  // Abort outranks a same-cycle handshake.
  assign xfer     = (state_q == StStream) & st_valid_q & bus.st_ready_i & ~bus.st_abort_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      tgt_q      <= '0;
      st_valid_q <= 1'b0;
      st_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      tgt_q      <= tgt_d;
      st_valid_q <= st_valid_d;
      if (load) st_data_q <= mem_q[load_idx];
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (bus.st_start_i) state_d = StStream;
      StStream: begin
        if (bus.st_abort_i)      state_d = StIdle;
        else if (xfer && last_row) state_d = StDone;
      end
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    ptr_d      = ptr_q;
    tgt_d      = tgt_q;
    st_valid_d = st_valid_q;
    load       = 1'b0;
    load_idx   = cur_idx;
    unique case (state_q)
      StIdle: begin
        if (bus.st_start_i) begin
          tgt_d      = bus.st_target_i;
          ptr_d      = '0;
          load       = 1'b1;
          load_idx   = row_idx(bus.st_target_i, '0);
          st_valid_d = 1'b1;
        end
      end
      StStream: begin
        if (bus.st_abort_i) begin
          st_valid_d = 1'b0;
        end else if (xfer) begin
          if (last_row) begin
            st_valid_d = 1'b0;
          end else begin
            ptr_d      = ptr_q + AW'(1);
            load       = 1'b1;
            load_idx   = row_idx(tgt_q, ptr_q + AW'(1));
            st_valid_d = 1'b1;
          end
        end
      end
      StDone:  st_valid_d = 1'b0;
      default: st_valid_d = 1'b0;
    endcase
  end

  // Memory and direct read port; all reads see pre-edge contents (old data on collision).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
`ifdef SP_CLEAR_ON_STREAM_EN
      if (xfer) mem_q[cur_idx] <= '0;
`endif
      // Later assignment wins, so a concurrent write overrides the clear.
      if (bus.wr_en_i) mem_q[wr_idx] <= bus.wr_data_i;
      rd_valid_q <= bus.rd_en_i;
      if (bus.rd_en_i) rd_data_q <= mem_q[rd_idx];
    end
  end

  assign bus.rd_data_o  = rd_data_q;
  assign bus.rd_valid_o = rd_valid_q;
  assign bus.st_data_o  = st_data_q;
  assign bus.st_valid_o = st_valid_q;
  assign bus.st_last_o  = st_valid_q & last_row;
  assign bus.st_busy_o  = (state_q != StIdle);
  assign bus.st_done_o  = (state_q == StDone);
endmodule
